dds_bank: RTL and testbench

Multi-channel direct digital synthesis core. It generalises the single-channel DDS in the signal generator to `CHANNELS` independent phase accumulators of parametrised width, each with:

- a tuning word, a phase offset and a waveform mode;
- double-buffered configuration applied to all channels on one commit strobe;
- a global phase sync.

It sits between the host command decoder (register writes) and the DAC pins.

---
 rtl/dds_bank.sv | 130 +++++++++++++
 tb/tb_dds_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_bank.sv
// Multi-channel DDS bank: per-channel phase accumulators with double-buffered
// tuning word / phase offset / waveform mode, a global commit and a global sync.
// Each channel's sample is one register stage behind its accumulator.
module dds_bank #(
  parameter int CHANNELS  = 2,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          wr_en,
  input  logic [CH_W-1:0]               wr_ch,
  input  logic [1:0]                    wr_sel,
  input  logic [ACC_WIDTH-1:0]          wr_data,
  input  logic                          commit,
  input  logic                          sync,
  output logic                          pending,
  output logic [CHANNELS*OUT_WIDTH-1:0] out
);

  // Shadow (host-visible) configuration
  logic [ACC_WIDTH-1:0] tw_s     [CHANNELS];
  logic [ACC_WIDTH-1:0] ph_s     [CHANNELS];
  logic [1:0]           mode_s   [CHANNELS];

  // Shadow contents after this cycle's write; commit copies these so a
  // same-cycle write is part of the commit.
  logic [ACC_WIDTH-1:0] tw_s_nxt   [CHANNELS];
  logic [ACC_WIDTH-1:0] ph_s_nxt   [CHANNELS];
  logic [1:0]           mode_s_nxt [CHANNELS];
  logic                 wr_hit;

  // Active configuration
  logic [ACC_WIDTH-1:0] tw   [CHANNELS];
  logic [ACC_WIDTH-1:0] ph   [CHANNELS];
  logic [1:0]           mode [CHANNELS];

  logic [ACC_WIDTH-1:0]          acc_p0 [CHANNELS];
  logic [CHANNELS*OUT_WIDTH-1:0] out_p1;

  // Waveform shaping of one phase value: sawtooth, square, triangle, off.
  function automatic logic [OUT_WIDTH-1:0] shape(input logic [ACC_WIDTH-1:0] p,
                                                 input logic [1:0]           m);
    logic [OUT_WIDTH-1:0] t;
    logic [OUT_WIDTH-1:0] u;
    t = p[ACC_WIDTH-1 -: OUT_WIDTH];
    u = {t[OUT_WIDTH-2:0], 1'b0};
    case (m)
      2'd0:    shape = t;
      2'd1:    shape = t[OUT_WIDTH-1] ? '1 : '0;
      2'd2:    shape = t[OUT_WIDTH-1] ? ~u : u;
      default: shape = '0;
    endcase
  endfunction

  // Decode the register write into next shadow values; reserved field or
  // out-of-range channel leaves everything untouched.
  always_comb begin
    wr_hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      tw_s_nxt[k]   = tw_s[k];
      ph_s_nxt[k]   = ph_s[k];
      mode_s_nxt[k] = mode_s[k];
      if (wr_en && (wr_sel != 2'd3) && (wr_ch == CH_W'(k))) begin
        wr_hit = 1'b1;
        case (wr_sel)
          2'd0:    tw_s_nxt[k]   = wr_data;
          2'd1:    ph_s_nxt[k]   = wr_data;
          2'd2:    mode_s_nxt[k] = wr_data[1:0];
          default: ;
        endcase
      end
    end
  end

  // Configuration registers, pending flag and phase accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        tw_s[k]   <= '0;
        ph_s[k]   <= '0;
        mode_s[k] <= '0;
        tw[k]     <= '0;
        ph[k]     <= '0;
        mode[k]   <= '0;
        acc_p0[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        tw_s[k]   <= tw_s_nxt[k];
        ph_s[k]   <= ph_s_nxt[k];
        mode_s[k] <= mode_s_nxt[k];
        if (commit) begin
          tw[k]   <= tw_s_nxt[k];
          ph[k]   <= ph_s_nxt[k];
          mode[k] <= mode_s_nxt[k];
        end
        // Stage p0: accumulator steps with the tuning word active before this edge
        if (sync) begin
          acc_p0[k] <= '0;
        end else if (en) begin
          acc_p0[k] <= acc_p0[k] + tw[k];
        end
      end
      if (commit) begin
        pending <= 1'b0;
      end else if (wr_hit) begin
        pending <= 1'b1;
      end
    end
  end

  // Output register: phase offset and waveform shaping, updated every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1 <= '0;
    end else begin
      // Stage p1: shaped sample from the registered accumulator
      for (int k = 0; k < CHANNELS; k++) begin
        out_p1[k*OUT_WIDTH +: OUT_WIDTH] <= shape(acc_p0[k] + ph[k], mode[k]);
      end
    end
  end

  assign out = out_p1;

endmodule

// File: tb/tb_dds_bank.sv
// Bench for dds_bank (2 channels, 16-bit accumulator, 8-bit samples).
// A cycle model pushes the expected {out, pending} after every clock edge;
// a monitor on the falling edge pops and compares against the DUT.
module tb_dds_bank;
  localparam int CH = 2;
  localparam int AW = 16;
  localparam int OW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             wr_en;
  logic [0:0]       wr_ch;
  logic [1:0]       wr_sel;
  logic [AW-1:0]    wr_data;
  logic             commit;
  logic             sync;
  logic             pending;
  logic [CH*OW-1:0] out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [CH*OW-1:0] smp;
    logic             pend;
  } exp_t;
  exp_t sb_q[$];

  dds_bank #(.CHANNELS(CH), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_sel(wr_sel), .wr_data(wr_data), .commit(commit), .sync(sync),
    .pending(pending), .out(out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_tw_s[CH], m_ph_s[CH], m_tw[CH], m_ph[CH], m_acc[CH];
  int          m_mode_s[CH], m_mode[CH];
  logic        m_pend;

  function automatic int ref_wave(input logic [15:0] p, input int md);
    int t;
    t = int'(p) / 256;
    case (md)
      0:       return t;
      1:       return (t >= 128) ? 255 : 0;
      2:       return (t < 128) ? 2 * t : 511 - 2 * t;
      default: return 0;
    endcase
  endfunction

  // Model: evaluate the edge from pre-edge inputs, push the expected result
  always @(posedge clk) begin
    exp_t e;
    logic hit;
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        m_tw_s[k] = 0; m_ph_s[k] = 0; m_tw[k] = 0; m_ph[k] = 0; m_acc[k] = 0;
        m_mode_s[k] = 0; m_mode[k] = 0;
      end
      m_pend = 1'b0;
      e.smp  = '0;
    end else begin
      for (int k = 0; k < CH; k++)
        e.smp[k*OW +: OW] = 8'(ref_wave(16'(m_acc[k] + m_ph[k]), m_mode[k]));
      hit = wr_en && (wr_sel != 2'd3) && (int'(wr_ch) < CH);
      if (hit) begin
        if (wr_sel == 2'd0) m_tw_s[wr_ch]   = wr_data;
        if (wr_sel == 2'd1) m_ph_s[wr_ch]   = wr_data;
        if (wr_sel == 2'd2) m_mode_s[wr_ch] = int'(wr_data[1:0]);
      end
      for (int k = 0; k < CH; k++) begin
        if (sync)    m_acc[k] = 0;
        else if (en) m_acc[k] = 16'(m_acc[k] + m_tw[k]);
      end
      if (commit) begin
        for (int k = 0; k < CH; k++) begin
          m_tw[k] = m_tw_s[k]; m_ph[k] = m_ph_s[k]; m_mode[k] = m_mode_s[k];
        end
        m_pend = 1'b0;
      end else if (hit) begin
        m_pend = 1'b1;
      end
    end
    e.pend = m_pend;
    sb_q.push_back(e);
  end

  // Monitor: one scoreboard entry per cycle, checked away from the edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty cyc=%0d got=%h exp=<entry>", cyc, out);
    end else begin
      e = sb_q.pop_front();
      if (out !== e.smp) begin
        bad++;
        $display("FAIL out cyc=%0d got=%h exp=%h", cyc, out, e.smp);
      end
      total++;
      if (pending !== e.pend) begin
        bad++;
        $display("FAIL pending cyc=%0d got=%b exp=%b", cyc, pending, e.pend);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int sel, input logic [AW-1:0] d);
    wr_en = 1'b1; wr_ch = 1'(ch); wr_sel = 2'(sel); wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic do_commit(input logic with_sync);
    commit = 1'b1; sync = with_sync;
    tick(1);
    commit = 1'b0; sync = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); wr_en = 1'($urandom); wr_ch = 1'($urandom);
      wr_sel = 2'($urandom); wr_data = 16'($urandom);
      commit = 1'($urandom); sync = 1'($urandom);
      tick(1);
    end
    rst = 1'b0; en = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = '0;
    wr_data = '0; commit = 1'b0; sync = 1'b0;
    tick(6);

    // Sawtooth and wrap on ch0
    wr(0, 0, 16'h0100);
    do_commit(1'b0);
    sync = 1'b1; tick(1); sync = 1'b0;
    tick(262);

    // Shadow isolation on ch1
    wr(1, 0, 16'h0200);
    tick(5);
    do_commit(1'b0);
    tick(12);

    // Square: tw=0, ph=0x8000
    wr(1, 0, 16'h0000);
    wr(1, 1, 16'h8000);
    wr(1, 2, 16'h0001);
    do_commit(1'b1);
    tick(10);

    // Triangle
    wr(1, 2, 16'h0002);
    wr(1, 0, 16'h0100);
    wr(1, 1, 16'h0000);
    do_commit(1'b1);
    tick(262);

    // Off
    wr(1, 2, 16'h0003);
    do_commit(1'b0);
    tick(5);

    // Write and commit in the same cycle
    wr_en = 1'b1; wr_ch = 1'b0; wr_sel = 2'd0; wr_data = 16'h0300; commit = 1'b1;
    tick(1);
    wr_en = 1'b0; commit = 1'b0;
    tick(10);

    // Sync and commit in the same cycle
    wr(0, 0, 16'h0500);
    do_commit(1'b1);
    tick(10);

    // Reserved field: no state change, pending unchanged (low, then high)
    wr(0, 3, 16'hFFFF);
    tick(3);
    wr(1, 0, 16'h0010);
    wr(0, 3, 16'h1234);
    tick(3);
    do_commit(1'b0);
    tick(4);

    // Hold
    en = 1'b0; tick(10);
    en = 1'b1; tick(5);

    // Reset mid-run with conflicting inputs, then rebuild configuration
    rst = 1'b1; wr_en = 1'b1; wr_ch = 1'b0; wr_sel = 2'd0; wr_data = 16'h0700;
    commit = 1'b1; sync = 1'b1;
    tick(1);
    rst = 1'b0; wr_en = 1'b0; commit = 1'b0; sync = 1'b0;
    tick(10);
    wr(0, 0, 16'h0100);
    wr(1, 0, 16'h0400);
    do_commit(1'b1);
    tick(12);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
